// File: rtl/operand_loader_pkg.sv
// Shared types and field helpers for the operand loader and the downstream
// bit-set stage: pair record, input FSM states, sign/magnitude extraction.
`ifndef OPERAND_LOADER_PKG_SV
`define OPERAND_LOADER_PKG_SV

// Sign bit and magnitude field of a sign-magnitude bit index of width n.
`define LOADER_SIGN(word, n) word[(n)-1]
`define LOADER_MAG(word, n)  word[(n)-2:0]

package operand_loader_pkg;

    // Operand width the pair record is built for.
    localparam int OPW = 8;

    typedef enum logic {
        ST_A = 1'b0,
        ST_B = 1'b1
    } ld_state_e;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic           inv;
    } pair_t;

endpackage

`endif

// File: rtl/operand_loader_pair_fifo.sv
// pair_fifo: DEPTH-entry circular buffer of operand pairs. DEPTH must be a
// power of two (2 or 4) so pointers wrap naturally. Head is read straight
// from registered storage, so it is stable until a pop.
module pair_fifo
    import operand_loader_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  push,
    input  logic  pop,
    input  pair_t push_data,
    output pair_t head,
    output logic  full,
    output logic  empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    pair_t         mem_q [DEPTH];
    pair_t         mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    // Clear overrides any push or pop in the same cycle.
    assign do_push = push && !full  && !clr;
    assign do_pop  = pop  && !empty && !clr;
    assign head    = mem_q[rd_ptr_q];

    // Pointer and occupancy update; clear empties the buffer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign mem_d[gi] = (do_push && (wr_ptr_q == PW'(gi))) ? push_data : mem_q[gi];

        // Entry storage, written only at the write pointer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) mem_q[gi] <= '0;
            else        mem_q[gi] <= mem_d[gi];
        end
    end

endmodule

// File: rtl/operand_loader.sv
// operand_loader: serial A-then-B operand intake with bit-index pre-check,
// buffering complete pairs in pair_fifo for the bit-set stage.
// Optional feature macro: LOADER_DROP_INV_EN (drop invalid pairs, count them).
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int N     = OPW,   // pair_t is sized by OPW, so N must equal it
    parameter int DEPTH = 2
) (
    input  logic         in_clk,
    input  logic         in_rst_n,
    input  logic         in_clr,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         o_ready,
    output logic [N-1:0] o_a,
    output logic [N-1:0] o_b,
    output logic         o_b_inv,
    output logic         o_valid,
    input  logic         in_ready
`ifdef LOADER_DROP_INV_EN
    ,
    output logic [7:0]   o_drop_cnt
`endif
);

    localparam logic [N-2:0] MAX_IDX = (N-1)'(N - 1);

    ld_state_e    state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic         inv;
    logic         push;
    logic         full;
    logic         empty;
    pair_t        push_data;
    pair_t        head;

    // B is a legal index only when positive and no larger than N-1.
    assign inv = `LOADER_SIGN(in_data, N) || (`LOADER_MAG(in_data, N) > MAX_IDX);

    assign push_data = '{a: a_q, b: in_data, inv: inv};

`ifdef LOADER_DROP_INV_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    assign o_drop_cnt = drop_cnt_q;
`endif

    // Input FSM: A is always taken; B is taken only when the FIFO has room.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        push    = 1'b0;
        o_ready = 1'b1;
`ifdef LOADER_DROP_INV_EN
        drop_cnt_d = drop_cnt_q;
`endif
        case (state_q)
            ST_A: begin
                if (in_valid) begin
                    a_d     = in_data;
                    state_d = ST_B;
                end
            end
            ST_B: begin
                o_ready = !full;
                if (in_valid && !full) begin
                    state_d = ST_A;
`ifdef LOADER_DROP_INV_EN
                    if (inv) begin
                        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                    end else begin
                        push = 1'b1;
                    end
`else
                    push = 1'b1;
`endif
                end
            end
            default: state_d = ST_A;
        endcase
        // Clear aborts a partial pair; A and the drop count are kept.
        if (in_clr) begin
            state_d = ST_A;
            a_d     = a_q;
            push    = 1'b0;
`ifdef LOADER_DROP_INV_EN
            drop_cnt_d = drop_cnt_q;
`endif
        end
    end

    // FSM, latched A word and drop counter registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_A;
            a_q     <= '0;
`ifdef LOADER_DROP_INV_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
`ifdef LOADER_DROP_INV_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .clr       (in_clr),
        .push      (push),
        .pop       (in_ready),
        .push_data (push_data),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign o_valid = !empty;
    assign o_a     = head.a;
    assign o_b     = head.b;
`ifdef LOADER_DROP_INV_EN
    assign o_b_inv = 1'b0;
`else
    assign o_b_inv = head.inv;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Directed testbench for operand_loader (N=8, DEPTH=2).
module tb_operand_loader;

    logic       in_clk;
    logic       in_rst_n;
    logic       in_clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       o_ready;
    logic [7:0] o_a;
    logic [7:0] o_b;
    logic       o_b_inv;
    logic       o_valid;
    logic       in_ready;
`ifdef LOADER_DROP_INV_EN
    logic [7:0] o_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    operand_loader #(.N(8), .DEPTH(2)) dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .in_clr   (in_clr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .o_ready  (o_ready),
        .o_a      (o_a),
        .o_b      (o_b),
        .o_b_inv  (o_b_inv),
        .o_valid  (o_valid),
        .in_ready (in_ready)
`ifdef LOADER_DROP_INV_EN
        ,
        .o_drop_cnt (o_drop_cnt)
`endif
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // Offer A then B on consecutive cycles (caller ensures B has room).
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        in_data  = a;
        in_valid = 1'b1;
        tick();
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        in_rst_n = 1'b0;
        in_clr   = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_ready = 1'b0;
        tick();
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        checks++; if (o_a !== 8'h00 || o_b !== 8'h00 || o_b_inv !== 1'b0) begin
            errors++; $display("FAIL reset_head got a=%h b=%h inv=%b exp 00 00 0", o_a, o_b, o_b_inv);
        end
        #2 in_rst_n = 1'b1;
        tick();
        $display("reset: valid=%b ready=%b", o_valid, o_ready);
    endtask

    task automatic test_basic();
        in_ready = 1'b1;
        send_pair(8'h10, 8'h03);
        checks++; if (o_valid !== 1'b1 || o_a !== 8'h10 || o_b !== 8'h03 || o_b_inv !== 1'b0) begin
            errors++; $display("FAIL basic_head got v=%b a=%h b=%h inv=%b exp 1 10 03 0", o_valid, o_a, o_b, o_b_inv);
        end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got valid=%b exp 0", o_valid); end
        $display("basic: pair 10/03 delivered and consumed");
    endtask

    task automatic test_invalid();
        in_ready = 1'b1;
        send_pair(8'h01, 8'h83);
`ifdef LOADER_DROP_INV_EN
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL inv_sign_drop got valid=%b exp 0", o_valid); end
`else
        checks++; if (o_valid !== 1'b1 || o_b !== 8'h83 || o_b_inv !== 1'b1) begin
            errors++; $display("FAIL inv_sign got v=%b b=%h inv=%b exp 1 83 1", o_valid, o_b, o_b_inv);
        end
`endif
        tick();
        send_pair(8'h02, 8'h08);
`ifdef LOADER_DROP_INV_EN
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL inv_mag_drop got valid=%b exp 0", o_valid); end
        checks++; if (o_drop_cnt !== 8'd2) begin errors++; $display("FAIL drop_cnt got %0d exp 2", o_drop_cnt); end
`else
        checks++; if (o_valid !== 1'b1 || o_b !== 8'h08 || o_b_inv !== 1'b1) begin
            errors++; $display("FAIL inv_mag got v=%b b=%h inv=%b exp 1 08 1", o_valid, o_b, o_b_inv);
        end
`endif
        tick();
        // Largest legal index.
        send_pair(8'h03, 8'h07);
        checks++; if (o_valid !== 1'b1 || o_b !== 8'h07 || o_b_inv !== 1'b0) begin
            errors++; $display("FAIL inv_max_ok got v=%b b=%h inv=%b exp 1 07 0", o_valid, o_b, o_b_inv);
        end
        tick();
        $display("invalid: B=83, B=08 flagged, B=07 accepted");
    endtask

    task automatic test_full();
        in_ready = 1'b0;
        send_pair(8'h11, 8'h01);
        send_pair(8'h22, 8'h02);
        checks++; if (o_valid !== 1'b1 || o_a !== 8'h11 || o_b !== 8'h01) begin
            errors++; $display("FAIL full_head1 got v=%b a=%h b=%h exp 1 11 01", o_valid, o_a, o_b);
        end
        in_data  = 8'h33;
        in_valid = 1'b1;
        tick();
        in_data = 8'h05;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", o_ready); end
        tick();
        in_ready = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_no_comb_path got %b exp 0", o_ready); end
        tick();
        in_ready = 1'b0;
        checks++; if (o_ready !== 1'b1 || o_a !== 8'h22 || o_b !== 8'h02) begin
            errors++; $display("FAIL full_after_pop got rdy=%b a=%h b=%h exp 1 22 02", o_ready, o_a, o_b);
        end
        tick();
        in_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_a !== 8'h22 || o_b !== 8'h02) begin
            errors++; $display("FAIL full_hold got v=%b a=%h b=%h exp 1 22 02", o_valid, o_a, o_b);
        end
        in_ready = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b1 || o_a !== 8'h33 || o_b !== 8'h05) begin
            errors++; $display("FAIL full_order got v=%b a=%h b=%h exp 1 33 05", o_valid, o_a, o_b);
        end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL full_drain got valid=%b exp 0", o_valid); end
        in_ready = 1'b0;
        $display("full: back-pressure and order 11,22,33 verified");
    endtask

    task automatic test_push_pop_same();
        in_ready = 1'b0;
        send_pair(8'h44, 8'h04);
        in_data  = 8'h55;
        in_valid = 1'b1;
        tick();
        in_data  = 8'h06;
        in_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_ready = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_a !== 8'h55 || o_b !== 8'h06) begin
            errors++; $display("FAIL pushpop_head got v=%b a=%h b=%h exp 1 55 06", o_valid, o_a, o_b);
        end
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL pushpop_count got valid=%b exp 0", o_valid); end
        $display("push_pop_same: head advanced to 55/06, count stayed 1");
    endtask

    task automatic test_reset_mid();
        in_ready = 1'b0;
        send_pair(8'h66, 8'h01);
        in_data  = 8'h77;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2 in_rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_a !== 8'h00) begin
            errors++; $display("FAIL rstmid_outputs got v=%b rdy=%b a=%h exp 0 1 00", o_valid, o_ready, o_a);
        end
        #2 in_rst_n = 1'b1;
        tick();
        send_pair(8'h09, 8'h02);
        checks++; if (o_valid !== 1'b1 || o_a !== 8'h09 || o_b !== 8'h02) begin
            errors++; $display("FAIL rstmid_next_is_a got v=%b a=%h b=%h exp 1 09 02", o_valid, o_a, o_b);
        end
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        $display("reset_mid: async reset cleared partial pair");
    endtask

    task automatic test_clear();
        in_ready = 1'b0;
        send_pair(8'hA1, 8'h01);
        send_pair(8'hA2, 8'h02);
        in_data  = 8'hA3;
        in_valid = 1'b1;
        tick();
        in_data = 8'h03;
        in_clr  = 1'b1;
        tick();
        in_clr   = 1'b0;
        in_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL clear_state got v=%b rdy=%b exp 0 1", o_valid, o_ready);
        end
        send_pair(8'hB1, 8'h04);
        checks++; if (o_valid !== 1'b1 || o_a !== 8'hB1 || o_b !== 8'h04) begin
            errors++; $display("FAIL clear_next_is_a got v=%b a=%h b=%h exp 1 B1 04", o_valid, o_a, o_b);
        end
        in_ready = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL clear_drain got valid=%b exp 0", o_valid); end
        in_ready = 1'b0;
        $display("clear: FIFO emptied, FSM back to A");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_full();
        test_push_pop_same();
        test_reset_mid();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
